// File: rtl/cpu_alu_pkg.sv
// cpu_alu_pkg: shared mode codes, skid-buffer state encoding and MIN/MAX helpers
package cpu_alu_pkg;
    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_NEG  = 2'b01;
    localparam logic [1:0] MODE_INV  = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

    function automatic logic [63:0] min_val(input int w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] max_val(input int w);
        return min_val(w) - 64'd1;
    endfunction
endpackage

// File: rtl/operand_xform.sv
// operand_xform: combinational pass/negate/invert/abs with MIN overflow detect
module operand_xform import cpu_alu_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MIN = WIDTH'(min_val(WIDTH));
    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] neg;
    logic             uses_neg;

    always_comb begin
        neg      = ~din + WIDTH'(1);
        uses_neg = (mode == MODE_NEG) || (mode == MODE_ABS && din[WIDTH-1]);
        ovf      = uses_neg && (din == MIN);
        dout     = ovf ? (SAT_EN ? MAX : MIN) :
                   uses_neg ? neg :
                   (mode == MODE_INV) ? ~din : din;
    end
endmodule

// File: rtl/operand_conditioner.sv
// operand_conditioner: operand transform feeding a 2-entry valid/ready skid buffer
module operand_conditioner import cpu_alu_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter bit SAT_EN = 1'b0,
    parameter int MODE_W = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [MODE_W-1:0] IN_MODE,
    input  logic [WIDTH-1:0]  IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [WIDTH-1:0]  OUT_DATA,
    output logic              OUT_OVF
);
    if (MODE_W != 2) begin : g_bad_mode_w
        $error("operand_conditioner: MODE_W must be 2");
    end

    logic [WIDTH-1:0] x_data;
    logic             x_ovf;

    operand_xform #(.WIDTH(WIDTH), .SAT_EN(SAT_EN)) u_xform (
        .mode (IN_MODE[1:0]),
        .din  (IN_DATA),
        .dout (x_data),
        .ovf  (x_ovf)
    );

    // Beats are stored as {ovf, data}
    state_e           state_q, state_d;
    logic [WIDTH:0]   main_q, main_d, skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire, out_fire;

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = state_q != ST_EMPTY;
    assign OUT_DATA  = main_q[WIDTH-1:0];
    assign OUT_OVF   = main_q[WIDTH];
    assign in_fire   = IN_VALID && in_ready_q;
    assign out_fire  = OUT_VALID && OUT_READY;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: if (in_fire) begin
                state_d = ST_ONE;
                main_d  = {x_ovf, x_data};
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = ST_FULL;
                    skid_d  = {x_ovf, x_data};
                end else if (in_fire) begin
                    main_d = {x_ovf, x_data};
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: if (out_fire) begin
                state_d = ST_ONE;
                main_d  = skid_q;
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = state_d != ST_FULL;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end
endmodule

// File: tb/tb_operand_conditioner.sv
// tb_operand_conditioner: scoreboard bench driving a wrap and a saturating instance in lockstep
module tb_operand_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_mode = 2'b00;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       in_ready0, in_ready1, out_valid0, out_valid1, out_ovf0, out_ovf1;
    logic [7:0] out_data0, out_data1;

    int n_pass = 0;
    int n_tot  = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    always #5 clk = ~clk;

    operand_conditioner #(.WIDTH(8), .SAT_EN(1'b0), .MODE_W(2)) dut0 (
        .CLK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready0),
        .IN_MODE(in_mode), .IN_DATA(in_data), .OUT_VALID(out_valid0),
        .OUT_READY(out_ready), .OUT_DATA(out_data0), .OUT_OVF(out_ovf0)
    );

    operand_conditioner #(.WIDTH(8), .SAT_EN(1'b1), .MODE_W(2)) dut1 (
        .CLK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready1),
        .IN_MODE(in_mode), .IN_DATA(in_data), .OUT_VALID(out_valid1),
        .OUT_READY(out_ready), .OUT_DATA(out_data1), .OUT_OVF(out_ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model in signed integer arithmetic, returns {ovf, data}
    function automatic logic [8:0] ref_model(input logic [1:0] m, input logic [7:0] d, input bit sat);
        int v, r;
        v = int'($signed(d));
        if ((m == 2'd1 || m == 2'd3) && v == -128) return {1'b1, sat ? 8'h7F : 8'h80};
        r = (m == 2'd0) ? v : (m == 2'd1) ? -v : (m == 2'd2) ? -v - 1 : (v < 0 ? -v : v);
        return {1'b0, 8'(r)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d);
        in_valid = v;
        in_mode  = m;
        in_data  = d;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) chk("sb0_unexpected", 32'(out_data0), 32'hFFFF);
                else chk("sb0", 32'({out_ovf0, out_data0}), 32'(q0.pop_front()));
            end
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("sb1_unexpected", 32'(out_data1), 32'hFFFF);
                else chk("sb1", 32'({out_ovf1, out_data1}), 32'(q1.pop_front()));
            end
            if (in_valid && in_ready0) begin
                q0.push_back(ref_model(in_mode, in_data, 1'b0));
                q1.push_back(ref_model(in_mode, in_data, 1'b1));
            end
        end
    end

    initial begin
        logic [1:0] modes[4];
        logic [7:0] datas[4];
        logic [7:0] exps[4];
        int sent;
        modes = '{2'd0, 2'd1, 2'd2, 2'd3};
        datas = '{8'h05, 8'h05, 8'h05, 8'hFB};
        exps  = '{8'h05, 8'hFB, 8'hFA, 8'h05};

        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid0), 0);
        chk("rst_ready", 32'(in_ready0), 1);
        chk("rst_data", 32'({out_ovf0, out_data0}), 0);

        // Back-to-back mode sweep with 1-cycle latency
        for (int i = 0; i < 5; i++) begin
            step();
            if (i < 4) drive(1'b1, modes[i], datas[i]);
            else drive(1'b0, 2'd0, 8'h00);
            @(negedge clk);
            if (i > 0) begin
                chk("seq_valid", 32'(out_valid0), 1);
                chk("seq_data", 32'(out_data0), 32'(exps[i-1]));
                chk("seq_ovf", 32'(out_ovf0), 0);
            end
        end

        // Overflow corners
        step(); drive(1'b1, 2'd1, 8'h80);
        step(); drive(1'b1, 2'd1, 8'h00);
        @(negedge clk);
        chk("neg_min_wrap", 32'({out_ovf0, out_data0}), 32'h180);
        chk("neg_min_sat", 32'({out_ovf1, out_data1}), 32'h17F);
        step(); drive(1'b1, 2'd3, 8'h80);
        @(negedge clk);
        chk("neg_zero", 32'({out_ovf0, out_data0}), 32'h000);
        step(); drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        chk("abs_min_sat", 32'({out_ovf1, out_data1}), 32'h17F);
        chk("abs_min_wrap", 32'({out_ovf0, out_data0}), 32'h180);

        // Backpressure fills the skid entry
        step(); out_ready = 1'b0; drive(1'b1, 2'd0, 8'h11);
        step(); drive(1'b1, 2'd0, 8'h22);
        @(negedge clk);
        chk("bp_ready_one", 32'(in_ready0), 1);
        step(); drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        chk("bp_ready_full", 32'(in_ready0), 0);
        chk("bp_hold", 32'(out_data0), 32'h11);
        step();
        @(negedge clk);
        chk("bp_hold2", 32'(out_data0), 32'h11);
        chk("bp_valid", 32'(out_valid0), 1);
        step(); out_ready = 1'b1;
        @(negedge clk);
        chk("bp_first", 32'(out_data0), 32'h11);
        step();
        @(negedge clk);
        chk("bp_second", 32'(out_data0), 32'h22);
        chk("bp_ready_back", 32'(in_ready0), 1);
        step();
        @(negedge clk);
        chk("bp_drained", 32'(out_valid0), 0);

        // Random streaming with random handshakes
        sent = 0;
        for (int c = 0; c < 2000 && sent < 100; c++) begin
            step();
            drive(1'($urandom_range(1)), 2'($urandom_range(3)), 8'($urandom_range(255)));
            if (($urandom_range(7)) == 0) in_data = 8'h80;
            out_ready = 1'($urandom_range(1));
            @(negedge clk);
            if (in_valid && in_ready0) sent++;
        end
        chk("stream_sent", 32'(sent), 100);
        step(); drive(1'b0, 2'd0, 8'h00); out_ready = 1'b1;
        for (int c = 0; c < 20 && (q0.size() + q1.size()) != 0; c++) step();
        chk("stream_drain", 32'(q0.size() + q1.size()), 0);

        // Reset while FULL
        step(); out_ready = 1'b0; drive(1'b1, 2'd0, 8'h44);
        step(); drive(1'b1, 2'd0, 8'h55);
        step(); drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        chk("full_before_rst", 32'(in_ready0), 0);
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("rstfull_valid", 32'(out_valid0), 0);
        chk("rstfull_data", 32'({out_ovf0, out_data0}), 0);
        chk("rstfull_ready", 32'(in_ready0), 1);
        step(); out_ready = 1'b1; drive(1'b1, 2'd0, 8'h33);
        step(); drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        chk("post_rst_first", 32'(out_data0), 32'h33);

        // Reset held low while upstream is valid
        step(); rst_n = 1'b0; drive(1'b1, 2'd1, 8'h07);
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            chk("rst_hold_valid", 32'(out_valid0), 0);
        end
        step(); rst_n = 1'b1; drive(1'b0, 2'd0, 8'h00);
        @(negedge clk);
        chk("rst_release_valid", 32'(out_valid0), 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
